// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Supports up to 32 requesters; an all-zero vector maps to index 0.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational; no latency, no backpressure.
// Assumes ptr < N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         pick,
    output logic                 pick_vld
);
    localparam int PW = $clog2(N);

    logic [N-1:0] rot;
    logic [N-1:0] lowest;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[PW'((i + int'(ptr)) % N)];
        end
    end

    // Rotated so that ptr sits at bit 0; isolate the lowest set bit.
    assign lowest = rot & (~rot + N'(1));

    always_comb begin
        pick = '0;
        for (int k = 0; k < N; k++) begin
            pick[k] = lowest[PW'((k + N - int'(ptr)) % N)];
        end
    end

    assign pick_vld = |req;

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port; grant locked per burst (max MAX_BURST beats).
// Latency: 1 idle arbitration cycle per burst, then 1 beat/cycle with combinational write path.
// Backpressure: ready of the granted requester follows ~i_fifo_full; grant held through stalls.
module fifo_wr_arb #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]       i_req_last,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic                     i_fifo_full,
    output logic                     o_fifo_wr,
    output logic [WIDTH-1:0]         o_fifo_wdata,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_busy
);
    import fifo_arb_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [NUM_REQ-1:0] pick;
    logic               pick_vld;
    logic [IW-1:0]      rr_ptr, ptr_nxt, g_idx;
    logic [CW-1:0]      beat_cnt, cnt_nxt;
    logic               busy, g_valid, g_last, beat, burst_end;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req      (i_req_valid),
        .ptr      (rr_ptr),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    assign busy      = (state == ARB_BURST);
    assign g_valid   = |(i_req_valid & o_grant);
    assign g_last    = |(i_req_last & o_grant);
    assign beat      = busy & g_valid & ~i_fifo_full;
    assign burst_end = beat & (g_last | (beat_cnt == CW'(MAX_BURST - 1)));
    assign g_idx     = IW'(onehot_to_idx(32'(o_grant)));

    assign o_req_ready = (busy & ~i_fifo_full) ? o_grant : '0;
    assign o_fifo_wr   = beat;
    assign o_busy      = busy;

    // Grant is one-hot in BURST and zero in IDLE, so the OR-mux reads 0 when idle.
    always_comb begin
        o_fifo_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_grant[k]) o_fifo_wdata = i_req_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = o_grant;
        ptr_nxt   = rr_ptr;
        cnt_nxt   = beat_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ARB_BURST;
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                end
            end
            ARB_BURST: begin
                if (burst_end) begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                    cnt_nxt   = '0;
                    ptr_nxt   = (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + IW'(1);
                end else if (beat) begin
                    cnt_nxt = beat_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ARB_IDLE;
            o_grant  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            o_grant  <= grant_nxt;
            rr_ptr   <= ptr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

endmodule
